// File: rtl/rename_table.sv
// rename_table: register rename map with a circular free list of rename tags.
//
// Two instructions per cycle (slot 0 older). Each source index is looked up in
// the map as it stands before this cycle's update. Each slot that writes a
// non-zero rd is offered a tag from the head of the free list. Retired tags
// come back at the tail through two release ports.
//
// Ports
//   clk, srst          clock, synchronous active-high reset
//   i_rs_1, i_rs_2     [slot] 5-bit architectural source indices
//   i_rd, i_writes     [slot] destination index and write enable
//   i_alloc            accept the slot pair this cycle
//   i_halt             freeze: no allocation, no mapping update
//   o_rs_1, o_rs_2     [slot] 6-bit current mapping (tag, or {1'b0,index})
//   o_rn               [slot] tag offered for rd, 0 when none
//   o_stall            not enough free tags for the pair
//   i_release_*        [port] commit-side tag return (valid, tag, rd)
//   i_flush            drop all speculative mappings, refill the free list
//   o_panic            sticky protocol-error flag
module rename_table #(
  parameter int TAGS = 32
) (
  input  logic            clk,
  input  logic            srst,
  input  logic [1:0][4:0] i_rs_1,
  input  logic [1:0][4:0] i_rs_2,
  input  logic [1:0][4:0] i_rd,
  input  logic [1:0]      i_writes,
  input  logic            i_alloc,
  input  logic            i_halt,
  output logic [1:0][5:0] o_rs_1,
  output logic [1:0][5:0] o_rs_2,
  output logic [1:0][5:0] o_rn,
  output logic            o_stall,
  input  logic [1:0]      i_release_valid,
  input  logic [1:0][5:0] i_release_tag,
  input  logic [1:0][4:0] i_release_rd,
  input  logic            i_flush,
  output logic            o_panic
);

  localparam int PW = $clog2(TAGS);
  localparam int CW = $clog2(TAGS) + 1;
  localparam logic [PW:0]   TAGS_P  = TAGS[PW:0];
  localparam logic [CW-1:0] TAGS_C  = TAGS[CW-1:0];
  localparam logic [6:0]    TAG_END = 7'(32 + TAGS);

  logic [5:0]    map_reg [32];
  logic [5:0]    map_next [32];
  logic [5:0]    fl_reg [TAGS];
  logic [5:0]    fl_next [TAGS];
  logic [PW-1:0] head_reg, head_next, head_1;
  logic [PW-1:0] tail_reg, tail_next, tail_w1;
  logic [CW-1:0] count_reg, count_next;
  logic          panic_reg;

  logic [1:0] need;
  logic [1:0] need_cnt, alloc_cnt, rel_cnt;
  logic       alloc_go;
  logic [1:0] rel_ok, rel_bad, in_range;
  logic       room0, room1;

  // Pointer add modulo TAGS (n is at most 2).
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + (PW + 1)'(n);
    if (s >= TAGS_P) s = s - TAGS_P;
    return s[PW-1:0];
  endfunction

  assign need[0]  = i_writes[0] && (i_rd[0] != 5'd0);
  assign need[1]  = i_writes[1] && (i_rd[1] != 5'd0);
  assign need_cnt = {1'b0, need[0]} + {1'b0, need[1]};
  assign o_stall  = CW'(need_cnt) > count_reg;
  assign head_1   = wrap_add(head_reg, 2'd1);
  assign alloc_go = i_alloc && !i_halt && !o_stall && !i_flush;
  assign alloc_cnt = alloc_go ? need_cnt : 2'd0;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      o_rs_1[s] = (i_rs_1[s] == 5'd0) ? 6'h00 : map_reg[i_rs_1[s]];
      o_rs_2[s] = (i_rs_2[s] == 5'd0) ? 6'h00 : map_reg[i_rs_2[s]];
    end
  end

  // Slot 1 takes head+1 only when slot 0 also consumed a tag.
  always_comb begin
    o_rn[0] = 6'h00;
    o_rn[1] = 6'h00;
    if (!o_stall) begin
      if (need[0]) o_rn[0] = fl_reg[head_reg];
      if (need[1]) o_rn[1] = need[0] ? fl_reg[head_1] : fl_reg[head_reg];
    end
  end

  // Release 1 sees the room left after release 0 was accepted; a flush
  // swallows releases without flagging them.
  always_comb begin
    in_range[0] = i_release_tag[0][5] && ({1'b0, i_release_tag[0]} < TAG_END);
    in_range[1] = i_release_tag[1][5] && ({1'b0, i_release_tag[1]} < TAG_END);
    room0       = count_reg < TAGS_C;
    rel_ok[0]   = !i_flush && i_release_valid[0] && in_range[0] && room0;
    room1       = (count_reg + CW'(rel_ok[0])) < TAGS_C;
    rel_ok[1]   = !i_flush && i_release_valid[1] && in_range[1] && room1;
    rel_bad[0]  = !i_flush && i_release_valid[0] && !(in_range[0] && room0);
    rel_bad[1]  = !i_flush && i_release_valid[1] && !(in_range[1] && room1);
  end

  assign rel_cnt    = {1'b0, rel_ok[0]} + {1'b0, rel_ok[1]};
  assign tail_w1    = rel_ok[0] ? wrap_add(tail_reg, 2'd1) : tail_reg;
  assign tail_next  = wrap_add(tail_reg, rel_cnt);
  assign head_next  = wrap_add(head_reg, alloc_cnt);
  assign count_next = count_reg - CW'(alloc_cnt) + CW'(rel_cnt);

  // Per-entry map update: slot 1 beats slot 0 beats a release clear, so a
  // same-cycle allocation of the rd always suppresses the clear.
  for (genvar gi = 0; gi < 32; gi++) begin : g_map
    logic hit0, hit1, clr;
    assign hit0 = alloc_go && need[0] && (i_rd[0] == 5'(gi));
    assign hit1 = alloc_go && need[1] && (i_rd[1] == 5'(gi));
    assign clr  = (rel_ok[0] && (i_release_rd[0] == 5'(gi)) && (map_reg[gi] == i_release_tag[0])) ||
                  (rel_ok[1] && (i_release_rd[1] == 5'(gi)) && (map_reg[gi] == i_release_tag[1]));
    assign map_next[gi] = hit1 ? o_rn[1] : hit0 ? o_rn[0] : clr ? 6'(gi) : map_reg[gi];
  end

  for (genvar gi = 0; gi < TAGS; gi++) begin : g_fl
    assign fl_next[gi] = (rel_ok[0] && (tail_reg == PW'(gi))) ? i_release_tag[0] :
                         (rel_ok[1] && (tail_w1 == PW'(gi)))  ? i_release_tag[1] :
                         fl_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (srst || i_flush) begin
      for (int i = 0; i < 32; i++) map_reg[i] <= 6'(i);
      for (int i = 0; i < TAGS; i++) fl_reg[i] <= 6'(32 + i);
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= TAGS_C;
    end else begin
      for (int i = 0; i < 32; i++) map_reg[i] <= map_next[i];
      for (int i = 0; i < TAGS; i++) fl_reg[i] <= fl_next[i];
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) panic_reg <= 1'b0;
    else      panic_reg <= panic_reg | rel_bad[0] | rel_bad[1];
  end

  assign o_panic = panic_reg;

endmodule
